// File: rtl/seg_scan_mux_if.sv
// Display-side bundle for seg_scan_mux: BCD/control in from the converter, anode/cathode drive out.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);
  logic [4*NUM_DIGITS-1:0] BCD;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    blank_lz;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   digits;
  logic [6:0]              segments;
  logic                    dp_n;
  logic                    scan_tick;

  modport master (
    output BCD, dp, blank_lz, brightness,
    input  digits, segments, dp_n, scan_tick
  );

  modport slave (
    input  BCD, dp, blank_lz, brightness,
    output digits, segments, dp_n, scan_tick
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode 7-segment scanner: MSD-first scan, per-frame snapshot,
// leading-zero blanking, decimal points and PWM brightness. All outputs registered.
module seg_lane #(
  parameter bit NEVER_BLANK = 1'b0
) (
  input  logic [3:0] nib,
  input  logic       zero_above,
  output logic [6:0] glyph,
  output logic       lz
);
  assign lz = zero_above && (nib == 4'd0) && !NEVER_BLANK;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes render as a dash
  always_comb begin
    glyph = 7'h3F;
    case (nib)
      4'd0: glyph = 7'h40;
      4'd1: glyph = 7'h79;
      4'd2: glyph = 7'h24;
      4'd3: glyph = 7'h30;
      4'd4: glyph = 7'h19;
      4'd5: glyph = 7'h12;
      4'd6: glyph = 7'h02;
      4'd7: glyph = 7'h78;
      4'd8: glyph = 7'h00;
      4'd9: glyph = 7'h10;
      default: glyph = 7'h3F;
    endcase
  end
endmodule

module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE_W = 17,
  parameter int BRIGHT_W   = 4
) (
  input  logic          CLK,
  input  logic          reset,
  seg_scan_mux_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRESCALE_W-1:0]          cnt;
  logic [IDX_W-1:0]               idx;
  logic [NUM_DIGITS-1:0][3:0]     sh_bcd;
  logic [NUM_DIGITS-1:0]          sh_dp;
  logic                           sh_blz;

  logic [NUM_DIGITS-1:0][6:0]     glyph;
  logic [NUM_DIGITS-1:0]          lz;
  logic [NUM_DIGITS-1:0]          za;

  logic [NUM_DIGITS-1:0]          dig_q;
  logic [6:0]                     seg_q;
  logic                           dpn_q;
  logic                           tick_q;

  // Each lane sees whether every more-significant shadow nibble is zero
  for (genvar j = 0; j < NUM_DIGITS; j++) begin : g_lane
    if (j == NUM_DIGITS - 1) begin : g_top
      assign za[j] = 1'b1;
    end else begin : g_rest
      assign za[j] = ~|sh_bcd[NUM_DIGITS-1:j+1];
    end
    seg_lane #(.NEVER_BLANK(j == 0)) u_lane (
      .nib        (sh_bcd[j]),
      .zero_above (za[j]),
      .glyph      (glyph[j]),
      .lz         (lz[j])
    );
  end

  logic                cnt_max, last_slot, lit;
  logic [IDX_W-1:0]    cur_j;
  logic [BRIGHT_W-1:0] phase;

  assign cnt_max   = &cnt;
  assign last_slot = (idx == LAST);
  assign cur_j     = LAST - idx;
  assign phase     = cnt[PRESCALE_W-1 -: BRIGHT_W];
  // All-ones brightness bypasses the compare so the digit never goes dark
  assign lit       = !(sh_blz && lz[cur_j]) &&
                     ((&bus.brightness) || (phase < bus.brightness));

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= '0;
      sh_bcd <= '0;
      sh_dp  <= '0;
      sh_blz <= 1'b0;
      dig_q  <= '1;
      seg_q  <= 7'h7F;
      dpn_q  <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      tick_q <= cnt_max;
      if (cnt_max) idx <= last_slot ? '0 : idx + 1'b1;
      if (cnt_max && last_slot) begin
        sh_bcd <= bus.BCD;
        sh_dp  <= bus.dp;
        sh_blz <= bus.blank_lz;
      end
      if (lit) begin
        dig_q <= ~(NUM_DIGITS'(1) << cur_j);
        seg_q <= glyph[cur_j];
        dpn_q <= ~sh_dp[cur_j];
      end else begin
        dig_q <= '1;
        seg_q <= 7'h7F;
        dpn_q <= 1'b1;
      end
    end
  end

  assign bus.digits    = dig_q;
  assign bus.segments  = seg_q;
  assign bus.dp_n      = dpn_q;
  assign bus.scan_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux at 4 digits, 8 clocks/slot, 2-bit brightness.
module tb_seg_scan_mux;
  logic CLK = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  seg_scan_mux_if #(.NUM_DIGITS(4), .BRIGHT_W(2)) bus ();

  seg_scan_mux #(.NUM_DIGITS(4), .PRESCALE_W(3), .BRIGHT_W(2)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] anode(input int s);
    logic [3:0] m;
    m = 4'b1000 >> s;
    return ~m;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.BCD = 16'h0; bus.dp = 4'b0; bus.blank_lz = 1'b0; bus.brightness = 2'd3;
    repeat (3) step();
    n_chk++; if (bus.digits !== 4'b1111) begin n_fail++; $display("FAIL rst_digits got %b want 1111", bus.digits); end
    n_chk++; if (bus.segments !== 7'h7F) begin n_fail++; $display("FAIL rst_segments got %h want 7F", bus.segments); end
    n_chk++; if (bus.dp_n !== 1'b1) begin n_fail++; $display("FAIL rst_dp_n got %b want 1", bus.dp_n); end
    n_chk++; if (bus.scan_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got %b want 0", bus.scan_tick); end
    reset = 1'b0;
    step();
    n_chk++; if (bus.digits !== 4'b0111) begin n_fail++; $display("FAIL rel_digits got %b want 0111", bus.digits); end
    n_chk++; if (bus.segments !== 7'h40) begin n_fail++; $display("FAIL rel_segments got %h want 40", bus.segments); end
  endtask

  task automatic test_scan();
    logic [6:0] es [4];
    es = '{7'h79, 7'h24, 7'h30, 7'h19};
    bus.BCD = 16'h1234; bus.dp = 4'b0010;
    repeat (31) step();
    for (int i = 0; i < 32; i++) begin
      step();
      n_chk++; if (bus.digits !== anode(i/8)) begin n_fail++; $display("FAIL scan_digits i=%0d got %b want %b", i, bus.digits, anode(i/8)); end
      n_chk++; if (bus.segments !== es[i/8]) begin n_fail++; $display("FAIL scan_segments i=%0d got %h want %h", i, bus.segments, es[i/8]); end
      n_chk++; if (bus.dp_n !== ((i/8) != 2)) begin n_fail++; $display("FAIL scan_dp_n i=%0d got %b want %b", i, bus.dp_n, (i/8) != 2); end
      n_chk++; if (bus.scan_tick !== ((i%8) == 7)) begin n_fail++; $display("FAIL scan_tick i=%0d got %b want %b", i, bus.scan_tick, (i%8) == 7); end
    end
  endtask

  task automatic test_midframe();
    for (int i = 0; i < 32; i++) begin
      step();
      if (i == 9) bus.BCD = 16'h8888;
      if (i >= 16) begin
        n_chk++;
        if (bus.segments !== ((i < 24) ? 7'h30 : 7'h19)) begin
          n_fail++; $display("FAIL mid_old_segments i=%0d got %h want %h", i, bus.segments, (i < 24) ? 7'h30 : 7'h19);
        end
      end
    end
    for (int i = 0; i < 32; i++) begin
      step();
      n_chk++; if (bus.segments !== 7'h00) begin n_fail++; $display("FAIL mid_new_segments i=%0d got %h want 00", i, bus.segments); end
      n_chk++; if (bus.digits !== anode(i/8)) begin n_fail++; $display("FAIL mid_new_digits i=%0d got %b want %b", i, bus.digits, anode(i/8)); end
    end
  endtask

  task automatic test_blank();
    logic [3:0] ed [4];
    logic [6:0] es [4];
    bus.blank_lz = 1'b1; bus.BCD = 16'h0050; bus.dp = 4'b0;
    repeat (32) step();
    // frame with shadow 0050
    bus.BCD = 16'h0000;
    ed = '{4'b1111, 4'b1111, 4'b1101, 4'b1110};
    es = '{7'h7F, 7'h7F, 7'h12, 7'h40};
    for (int i = 0; i < 32; i++) begin
      step();
      n_chk++; if (bus.digits !== ed[i/8]) begin n_fail++; $display("FAIL blank50_digits i=%0d got %b want %b", i, bus.digits, ed[i/8]); end
      n_chk++; if (bus.segments !== es[i/8]) begin n_fail++; $display("FAIL blank50_segments i=%0d got %h want %h", i, bus.segments, es[i/8]); end
      n_chk++; if (bus.dp_n !== 1'b1) begin n_fail++; $display("FAIL blank50_dp_n i=%0d got %b want 1", i, bus.dp_n); end
    end
    // frame with shadow 0000
    bus.BCD = 16'h00C0;
    ed = '{4'b1111, 4'b1111, 4'b1111, 4'b1110};
    es = '{7'h7F, 7'h7F, 7'h7F, 7'h40};
    for (int i = 0; i < 32; i++) begin
      step();
      n_chk++; if (bus.digits !== ed[i/8]) begin n_fail++; $display("FAIL blank00_digits i=%0d got %b want %b", i, bus.digits, ed[i/8]); end
      n_chk++; if (bus.segments !== es[i/8]) begin n_fail++; $display("FAIL blank00_segments i=%0d got %h want %h", i, bus.segments, es[i/8]); end
    end
    // frame with shadow 00C0
    bus.BCD = 16'h1234; bus.blank_lz = 1'b0;
    ed = '{4'b1111, 4'b1111, 4'b1101, 4'b1110};
    es = '{7'h7F, 7'h7F, 7'h3F, 7'h40};
    for (int i = 0; i < 32; i++) begin
      step();
      n_chk++; if (bus.digits !== ed[i/8]) begin n_fail++; $display("FAIL blankC0_digits i=%0d got %b want %b", i, bus.digits, ed[i/8]); end
      n_chk++; if (bus.segments !== es[i/8]) begin n_fail++; $display("FAIL blankC0_segments i=%0d got %h want %h", i, bus.segments, es[i/8]); end
    end
  endtask

  task automatic test_brightness();
    logic [1:0] bv [4];
    int         on [4];
    logic [6:0] es [4];
    bv = '{2'd1, 2'd2, 2'd0, 2'd3};
    on = '{2, 4, 0, 8};
    es = '{7'h79, 7'h24, 7'h30, 7'h19};
    for (int b = 0; b < 4; b++) begin
      bus.brightness = bv[b];
      for (int i = 0; i < 32; i++) begin
        logic lit;
        step();
        lit = (i%8) < on[b];
        n_chk++;
        if (bus.digits !== (lit ? anode(i/8) : 4'b1111)) begin
          n_fail++; $display("FAIL bright%0d_digits i=%0d got %b want %b", bv[b], i, bus.digits, lit ? anode(i/8) : 4'b1111);
        end
        n_chk++;
        if (bus.segments !== (lit ? es[i/8] : 7'h7F)) begin
          n_fail++; $display("FAIL bright%0d_segments i=%0d got %h want %h", bv[b], i, bus.segments, lit ? es[i/8] : 7'h7F);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.brightness = 2'd3;
    repeat (21) step();
    reset = 1'b1;
    step();
    n_chk++; if (bus.digits !== 4'b1111) begin n_fail++; $display("FAIL midrst_digits got %b want 1111", bus.digits); end
    n_chk++; if (bus.segments !== 7'h7F) begin n_fail++; $display("FAIL midrst_segments got %h want 7F", bus.segments); end
    n_chk++; if (bus.dp_n !== 1'b1) begin n_fail++; $display("FAIL midrst_dp_n got %b want 1", bus.dp_n); end
    n_chk++; if (bus.scan_tick !== 1'b0) begin n_fail++; $display("FAIL midrst_tick got %b want 0", bus.scan_tick); end
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      n_chk++; if (bus.scan_tick !== (i == 7)) begin n_fail++; $display("FAIL postrst_tick i=%0d got %b want %b", i, bus.scan_tick, i == 7); end
      if (i == 0 || i == 8) begin
        n_chk++; if (bus.digits !== anode(i/8)) begin n_fail++; $display("FAIL postrst_digits i=%0d got %b want %b", i, bus.digits, anode(i/8)); end
        // shadow was cleared, so slot 1 shows '0' rather than '2'
        n_chk++; if (bus.segments !== 7'h40) begin n_fail++; $display("FAIL postrst_segments i=%0d got %h want 40", i, bus.segments); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe();
    test_blank();
    test_brightness();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexed 7-segment display driver with built-in segment decode. It scans NUM_DIGITS common-anode digits from a packed BCD word, each digit holding for a power-of-two number of clocks. Beyond plain scanning it adds per-frame input snapshotting, leading-zero blanking, per-digit decimal points and PWM brightness control. It sits between the frequency-count BCD converter and the board's anode/cathode pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- PRESCALE_W, 17, log2 of clocks per digit slot; slot length = 2^PRESCALE_W
- BRIGHT_W, 4, brightness control width; must be ≤ PRESCALE_W
- CLK  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- BCD  in  4*NUM_DIGITS  packed digits; nibble j = BCD[4j+3:4j], j = NUM_DIGITS-1 is most significant
- dp  in  NUM_DIGITS  decimal point request; bit j belongs to nibble j
- blank_lz  in  1  1 = enable leading-zero blanking
- brightness  in  BRIGHT_W  on-time control, sampled live (not snapshotted)
- digits  out  NUM_DIGITS  active-low anodes; bit j low = nibble j displayed
- segments  out  7  active-low cathodes {g,f,e,d,c,b,a}
- dp_n  out  1  active-low decimal point cathode
- scan_tick  out  1  one-cycle pulse per slot advance

## Operation
- State: prescale counter cnt (PRESCALE_W bits), slot index idx (0..NUM_DIGITS-1), and a shadow copy of BCD, dp and blank_lz.
- cnt increments every cycle and wraps at 2^PRESCALE_W-1.
- On cnt wrap, idx advances. When idx is NUM_DIGITS-1, it wraps to 0.
- Slot idx displays nibble j = NUM_DIGITS-1-idx. Scan order is MSD first.
- Shadow loads BCD/dp/blank_lz on the edge where idx = NUM_DIGITS-1 and cnt is all ones, so every frame shows one coherent sample. Input changes mid-frame have no effect until the next frame.
- Decode: 0..9 map to the standard glyphs. Nibble values 10..15 show a dash (g only, 7'h3F).
- Leading-zero blanking applies when shadow blank_lz = 1:
  - Nibble j is blanked if it and all more-significant nibbles are 0.
  - Nibble 0 is never blanked.
- Brightness:
  - phase = cnt[PRESCALE_W-1 -: BRIGHT_W].
  - The digit is lit when phase < brightness, or when brightness is all ones (always lit).
  - brightness = 0 means dark.
- Dark slot (blanked or PWM off): digits all ones, segments 7'h7F, dp_n 1.
- Lit slot: digits has only bit j low; segments = decode(nibble j); dp_n = ~shadow dp[j].
- Reset values: cnt 0, idx 0, shadow 0. Outputs: digits all ones, segments 7'h7F, dp_n 1, scan_tick 0.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect cnt, idx and shadow in cycle t, so latency is 1 cycle.
- The first output cycle after reset release shows slot 0 with the reset shadow (all zeros).
- The first real BCD sample is taken at the end of frame 0.
- scan_tick is high for exactly one cycle, the cycle after cnt = all ones. Period = 2^PRESCALE_W cycles.
- Reset asserted mid-slot or mid-frame: the next edge forces all reset values. Scanning restarts at slot 0 in the cycle after release.
- Reset coinciding with a shadow-load edge: reset wins and the shadow stays 0.
- A brightness change takes effect on the next cycle's output, within the current slot.

## Test plan
Bench parameters: NUM_DIGITS=4, PRESCALE_W=3 (8 cycles/slot), BRIGHT_W=2.

1. **Reset.** Hold reset 3 cycles -> digits=4'b1111, segments=7'h7F, dp_n=1, scan_tick=0. Release with brightness=3, blank_lz=0 -> next cycle digits=4'b0111, segments=7'h40 ('0').
2. **Scan and snapshot.** BCD=16'h1234, dp=4'b0010, wait one frame. Slots show, 8 cycles each:
   - 0111/7'h79
   - 1011/7'h24
   - 1101/7'h30 with dp_n=0
   - 1110/7'h19

   scan_tick pulses every 8 cycles.
3. **Mid-frame change.** Change BCD to 16'h8888 during slot 1 -> slots 2,3 still show '3','4'. The next frame shows 7'h00 on all digits.
4. **Blanking and invalid nibbles.** blank_lz=1:
   - BCD=16'h0050 -> digits stays 4'b1111 during slots 0,1; slot 2 shows 7'h12; slot 3 shows 7'h40.
   - BCD=16'h0000 -> only slot 3 lit with '0'.
   - BCD=16'h00C0 -> slot 2 shows 7'h3F.
5. **Brightness.** brightness=1 -> anode low only for cnt 0..1 of each slot (2 of 8 cycles). brightness=0 -> anodes always 4'b1111. brightness=3 -> lit all 8 cycles.
6. **Reset mid-slot.** Assert reset at cnt=5 in slot 2 -> next cycle outputs at reset values. After release: slot 0 again, scan_tick first pulses 8 cycles later.
